// File: rtl/time_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : time_display_driver
// Purpose  : Multiplexes six BCD digits (MM:SS:hh) onto a common-anode 7-seg
//            display. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module time_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] disp_time,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an
);
    localparam int               CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [2:0]       IDX_MAX = 3'd5;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [23:0]      snap_q, snap_d;
    logic             first_q, first_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [5:0]       an_q, an_d;
    logic             tick;
    logic [3:0]       nibble;
    logic             blank;

    always_comb begin
        tick    = (cnt_q == CNT_MAX);
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end
        // Snapshot only refreshes at scan boundaries so a scan never tears.
        snap_d  = (first_q || (tick && idx_q == IDX_MAX)) ? disp_time : snap_q;
        first_d = 1'b0;

        case (idx_q)
            3'd0:    nibble = snap_q[3:0];
            3'd1:    nibble = snap_q[7:4];
            3'd2:    nibble = snap_q[11:8];
            3'd3:    nibble = snap_q[15:12];
            3'd4:    nibble = snap_q[19:16];
            default: nibble = snap_q[23:20];
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        blank = ((idx_q == 3'd5) && (snap_q[23:20] == 4'd0)) ||
                ((idx_q == 3'd4) && (snap_q[23:16] == 8'd0));
`else
        blank = 1'b0;
`endif

        case (nibble)
            4'd0:    seg_d = 7'h40;
            4'd1:    seg_d = 7'h79;
            4'd2:    seg_d = 7'h24;
            4'd3:    seg_d = 7'h30;
            4'd4:    seg_d = 7'h19;
            4'd5:    seg_d = 7'h12;
            4'd6:    seg_d = 7'h02;
            4'd7:    seg_d = 7'h78;
            4'd8:    seg_d = 7'h00;
            4'd9:    seg_d = 7'h10;
            default: seg_d = 7'h3F;
        endcase

        dp_d = ~((idx_q == 3'd2) || (idx_q == 3'd4));
        if (blank) begin
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end
        an_d = ~(6'b000001 << idx_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            snap_q  <= 24'h000000;
            first_q <= 1'b1;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 6'h3F;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            first_q <= first_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_time_display_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_display_driver
// Purpose  : Directed self-checking bench for time_display_driver (REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_display_driver;
    logic        clk;
    logic        reset;
    logic [23:0] disp_time;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;

    int errors = 0;
    int checks = 0;

    time_display_driver #(.REFRESH_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .disp_time (disp_time),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h3F;
        endcase
    endfunction

    // Entered just after the edge that lights digit from_d; leaves just after
    // the edge that lights digit 0 of the following scan.
    task automatic scan_check(input logic [23:0] val, input int from_d);
        logic [6:0] exp_seg;
        logic       exp_dp;
        logic [5:0] exp_an;
        logic [5:0] one;
        for (int d = from_d; d < 6; d++) begin
            one     = 6'b000001;
            exp_an  = ~(one << d);
            exp_seg = enc(val[4*d +: 4]);
            exp_dp  = !(d == 2 || d == 4);
`ifdef LEADING_ZERO_BLANK_EN
            if ((d == 5 && val[23:20] == 4'd0) || (d == 4 && val[23:16] == 8'd0)) begin
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end
`endif
            adv(1);
            check($sformatf("an d%0d", d), an, exp_an);
            check($sformatf("seg d%0d val=%h", d, val), seg, exp_seg);
            check($sformatf("dp d%0d", d), dp, exp_dp);
            adv(2);
            check($sformatf("an hold d%0d", d), an, exp_an);
            adv(1);
        end
    endtask

    initial begin
        reset     = 1'b1;
        disp_time = 24'h123456;
        #2;
        check("reset an", an, 6'h3F);
        check("reset seg", seg, 7'h7F);
        check("reset dp", dp, 1'b1);
        adv(2);
        check("reset held an", an, 6'h3F);
        check("reset held seg", seg, 7'h7F);
        #3 reset = 1'b0;

        adv(1);
        check("first edge an", an, 6'h3E);
        scan_check(24'h123456, 0);

        adv(8);
        disp_time = 24'h000000;
        scan_check(24'h123456, 2);
        scan_check(24'h000000, 0);

        disp_time = 24'h0000A0;
        adv(24);
        scan_check(24'h0000A0, 0);

        disp_time = 24'h000512;
        adv(24);
        scan_check(24'h000512, 0);

        disp_time = 24'h010000;
        adv(24);
        scan_check(24'h010000, 0);

        // Assert reset between edges while digit 3 is lit.
        adv(13);
        check("pre-reset an d3", an, 6'h37);
        #3 reset = 1'b1;
        #1;
        check("async reset an", an, 6'h3F);
        check("async reset seg", seg, 7'h7F);
        check("async reset dp", dp, 1'b1);
        #2 reset = 1'b0;
        adv(1);
        check("restart an", an, 6'h3E);
        adv(1);
        check("restart an d0", an, 6'h3E);
        check("restart seg d0", seg, 7'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
